// File: rtl/avalon_tx_arbiter.sv
// Packet-atomic two-requester round-robin arbiter onto the shared Avalon-ST TX stream.
// Registered output stage with backpressure; enforces an idle gap after every packet.
module avalon_tx_arbiter #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int BE_WIDTH       = AXI_DATA_WIDTH / 8,
    parameter int GAP_CYCLES     = 1
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst_n,
    input  logic                      src0_valid,
    input  logic                      src0_sop,
    input  logic                      src0_eop,
    input  logic [AXI_DATA_WIDTH-1:0] src0_data,
    input  logic [BE_WIDTH-1:0]       src0_be,
    output logic                      src0_ready,
    input  logic                      src1_valid,
    input  logic                      src1_sop,
    input  logic                      src1_eop,
    input  logic [AXI_DATA_WIDTH-1:0] src1_data,
    input  logic [BE_WIDTH-1:0]       src1_be,
    output logic                      src1_ready,
    input  logic                      tx_st_ready,
    output logic                      tx_st_valid,
    output logic                      tx_st_sop,
    output logic                      tx_st_eop,
    output logic [AXI_DATA_WIDTH-1:0] tx_st_data,
    output logic [BE_WIDTH-1:0]       tx_st_be,
    output logic                      grant_id,
    output logic                      busy,
    output logic                      protocol_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_grant;
    logic                      r_last_grant;
    logic [3:0]                r_gap_cnt;
    logic                      r_first_beat;
    logic                      r_nosop0;
    logic                      r_nosop1;
    logic                      r_err;
    logic                      r_tx_valid;
    logic                      r_tx_sop;
    logic                      r_tx_eop;
    logic [AXI_DATA_WIDTH-1:0] r_tx_data;
    logic [BE_WIDTH-1:0]       r_tx_be;

    logic                      w_req0;
    logic                      w_req1;
    logic                      w_pick;
    logic                      w_out_free;
    logic                      w_ready0;
    logic                      w_ready1;
    logic                      w_accept;
    logic                      w_src_sop;
    logic                      w_src_eop;
    logic [AXI_DATA_WIDTH-1:0] w_src_data;
    logic [BE_WIDTH-1:0]       w_src_be;
    logic                      w_gap_done;
    logic                      w_stray0;
    logic                      w_stray1;

    // Handshakes: a beat moves on an edge where valid && ready; the output stage
    // holds its beat unchanged while tx_st_valid && !tx_st_ready (zero ready-latency).
    assign w_req0     = src0_valid && src0_sop;
    assign w_req1     = src1_valid && src1_sop;
    assign w_pick     = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
    assign w_out_free = !r_tx_valid || tx_st_ready;
    assign w_src_sop  = r_grant ? src1_sop  : src0_sop;
    assign w_src_eop  = r_grant ? src1_eop  : src0_eop;
    assign w_src_data = r_grant ? src1_data : src0_data;
    assign w_src_be   = r_grant ? src1_be   : src0_be;
    // Exit one edge early so the decrement to zero and the return to IDLE coincide.
    assign w_gap_done = !r_tx_valid && (r_gap_cnt <= 4'd1);
    assign w_stray0   = (r_state == S_IDLE) && src0_valid && !src0_sop && !w_req1;
    assign w_stray1   = (r_state == S_IDLE) && src1_valid && !src1_sop && !w_req0;

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_req0 || w_req1) w_next_state = S_XFER;
            S_XFER: if (w_accept && w_src_eop) w_next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (w_gap_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready0 = (r_state == S_XFER) && !r_grant && w_out_free;
        w_ready1 = (r_state == S_XFER) &&  r_grant && w_out_free;
        w_accept = (w_ready0 && src0_valid) || (w_ready1 && src1_valid);
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_gap_cnt    <= 4'd0;
            r_first_beat <= 1'b1;
            r_nosop0     <= 1'b0;
            r_nosop1     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && (w_req0 || w_req1)) r_grant <= w_pick;
            if (w_accept && w_src_eop) begin
                r_last_grant <= r_grant;
                r_gap_cnt    <= GAP_INIT;
            end else if ((r_state == S_GAP) && !r_tx_valid && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
            if (r_state == S_IDLE) r_first_beat <= 1'b1;
            else if (w_accept)     r_first_beat <= 1'b0;
            r_nosop0 <= w_stray0;
            r_nosop1 <= w_stray1;
            // Sticky: a mid-packet sop or a stray beat lingering in IDLE for two cycles.
            if ((w_accept && w_src_sop && !r_first_beat) ||
                (w_stray0 && r_nosop0) || (w_stray1 && r_nosop1)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_be    <= '0;
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_sop   <= w_src_sop;
            r_tx_eop   <= w_src_eop;
            r_tx_data  <= w_src_data;
            r_tx_be    <= w_src_be;
        end else if (tx_st_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign src0_ready   = w_ready0;
    assign src1_ready   = w_ready1;
    assign tx_st_valid  = r_tx_valid;
    assign tx_st_sop    = r_tx_sop;
    assign tx_st_eop    = r_tx_eop;
    assign tx_st_data   = r_tx_data;
    assign tx_st_be     = r_tx_be;
    assign grant_id     = r_grant;
    assign busy         = (r_state != S_IDLE) || r_tx_valid;
    assign protocol_err = r_err;

endmodule

// File: doc/avalon_tx_arbiter.md
Name: avalon_tx_arbiter

Overview:
- Packet-atomic, two-requester round-robin arbiter that shares the single Avalon-ST TX stream (tx_st_*) feeding the 128-bit TX alignment stage.
- Requester 0 is the completion engine; requester 1 is the DMA write engine.
- Output is a registered pipeline stage with backpressure.
- After every packet it enforces a programmable idle gap on the output. The alignment stage can extend a packet by one beat when a 3DW-header TLP ends on a full beat, and the gap absorbs that extension.

Parameters:
- AXI_DATA_WIDTH, 128, data beat width
- BE_WIDTH, AXI_DATA_WIDTH/8, byte-enable width
- GAP_CYCLES, 1, minimum output idle cycles between packets (0..15)

Ports:
- axi_clk  in  1  single clock
- axi_rst_n  in  1  asynchronous active-low reset
- src0_valid / src1_valid  in  1  requester beat valid
- src0_sop / src1_sop  in  1  requester start of packet
- src0_eop / src1_eop  in  1  requester end of packet
- src0_data / src1_data  in  AXI_DATA_WIDTH  requester beat data
- src0_be / src1_be  in  BE_WIDTH  requester byte enables
- src0_ready / src1_ready  out  1  beat accepted when valid && ready
- tx_st_ready  in  1  downstream ready, zero ready-latency
- tx_st_valid  out  1  output beat valid
- tx_st_sop  out  1  output start of packet
- tx_st_eop  out  1  output end of packet
- tx_st_data  out  AXI_DATA_WIDTH  output data
- tx_st_be  out  BE_WIDTH  output byte enables
- grant_id  out  1  requester currently owning the stream
- busy  out  1  state != IDLE or tx_st_valid
- protocol_err  out  1  sticky; cleared only by reset

Behaviour:
Reset (async, axi_rst_n=0):
- All outputs 0; state=IDLE; last_grant=1, so requester 0 wins the first tie; gap counter 0.
- Asserting reset mid-packet abandons the packet. Nothing is replayed.

State IDLE:
- A request is srcN_valid && srcN_sop.
- Both requesting: grant !last_grant. One requesting: grant that one.
- grant_id is registered and the state moves to XFER on the next edge.
- Both src_ready are 0 in IDLE.

State XFER:
- srcN_ready = (grant_id==N) && (!tx_st_valid || tx_st_ready). The non-granted ready is 0.
- Accepted beat loads the output register on the same edge. Beat latency is 1 cycle.
- First output beat appears 2 cycles after the request is first seen in IDLE, assuming tx_st_ready=1.
- Output register holds while tx_st_valid && !tx_st_ready. Data, be, sop and eop are stable while stalled.
- When tx_st_ready=1 and no beat is accepted, tx_st_valid drops to 0.
- Accepting a beat with eop sets last_grant=grant_id. Next state is GAP, or IDLE if GAP_CYCLES=0.

State GAP:
- Counter loads GAP_CYCLES on eop acceptance.
- Counter decrements only on cycles with tx_st_valid=0, i.e. after the eop beat has drained. This guarantees at least GAP_CYCLES idle output cycles regardless of backpressure.
- Counter at 0 → IDLE. Both src_ready are 0 in GAP.

Protocol errors (set protocol_err; datapath behaviour unchanged):
- Granted source presents sop on a non-first beat: flag set; the beat is forwarded as-is.
- Valid without sop in IDLE is ignored. Flag set if it persists 2 or more consecutive IDLE cycles while the other source is not requesting.
- Single-beat packet (sop && eop together) is legal.

Throughput and fairness:
- Back-to-back packets from one source with GAP_CYCLES=1 cost 3 idle cycles: drain, gap, IDLE arbitration.
- Grant never changes mid-packet.

Test Plan:
- Src0 only, 3-beat packet (D0 sop, D1, D2 eop), tx_st_ready=1 → tx_st_valid high 3 cycles starting 2 cycles after request; sop on D0, eop on D2; grant_id=0; src1_ready stays 0.
- Both sources request continuously, 2-beat packets each, GAP_CYCLES=1 → output order src0, src1, src0, src1; at least 1 idle output cycle between eop and next sop; grant_id switches only between packets.
- Src1 4-beat packet; tx_st_ready=0 for 3 cycles at beat 2 → beat 2 held stable 3 cycles; src1_ready=0 during the stall; no beat lost or duplicated; eop count = 1.
- GAP_CYCLES=3, src0 two back-to-back 1-beat packets → exactly 3 idle cycles after the first eop drains, then IDLE arbitration, then second sop.
- Src0 valid=1, sop=0 held 2 cycles in IDLE, src1 idle → protocol_err=1 and stays 1; no output beats; error clears only on axi_rst_n=0.
- Assert axi_rst_n=0 for 1 cycle during beat 2 of a 4-beat src0 packet → all outputs 0 immediately (async); after release src0 with new sop wins the tie against simultaneous src1.
